// File: rtl/nand_bus_seq.sv
// NAND flash bus sequencer: turns one READ/PROG/ERASE/ID request into CE/CLE/ALE/WE/RE
// strobe sequences with parameterised cycle timing, busy wait and status read-back.
module nand_bus_seq #(
  parameter int T_WP  = 2,
  parameter int T_WH  = 1,
  parameter int T_RP  = 2,
  parameter int T_REH = 1,
  parameter int T_WB  = 4,
  parameter int T_TMO = 2**20-1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [23:0] req_addr,
  input  logic [9:0]  req_len,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        done,
  output logic        err,
  output logic [7:0]  status,
  output logic        ceb,
  output logic        cle,
  output logic        ale,
  output logic        web,
  output logic        reb,
  output logic [7:0]  io_out,
  output logic        io_oe,
  input  logic [7:0]  io_in,
  input  logic        rbb
);
  typedef enum logic [3:0] {S_IDLE, S_CMD1, S_ADDR, S_WDATA, S_CMD2, S_WAITB,
                            S_RDATA, S_STCMD, S_STRD, S_DONE} state_t;
  localparam logic [1:0] OP_READ = 2'd0, OP_PROG = 2'd1, OP_ERASE = 2'd2, OP_ID = 2'd3;
  localparam logic [7:0] WLOW  = 8'(T_WP-1);
  localparam logic [7:0] WLAST = 8'(T_WP+T_WH-1);
  localparam logic [7:0] RLOW  = 8'(T_RP-1);
  localparam logic [7:0] RLAST = 8'(T_RP+T_REH-1);
  localparam int TW = $clog2(T_TMO+1);
  localparam logic [TW-1:0] TWB  = TW'(T_WB);
  localparam logic [TW-1:0] TMO1 = TW'(T_TMO-1);

  state_t        r_state;
  logic [1:0]    r_op, r_idx;
  logic [23:0]   r_addr;
  logic [9:0]    r_len, r_bcnt;
  logic [7:0]    r_cyc, r_io_out, r_rd_data, r_status;
  logic [TW-1:0] r_tmo;
  logic r_ceb, r_cle, r_ale, r_web, r_reb, r_io_oe, r_rd_valid, r_wr_ready, r_done, r_err;
  logic w_wr_st, w_rd_st, w_wend, w_rend;
  logic [1:0] w_alast;

  assign w_wr_st = r_state inside {S_CMD1, S_ADDR, S_WDATA, S_CMD2, S_STCMD};
  assign w_rd_st = r_state inside {S_RDATA, S_STRD};
  assign w_wend  = (r_cyc == WLAST);
  assign w_rend  = (r_cyc == RLAST);
  assign w_alast = (r_op == OP_ERASE) ? 2'd1 : (r_op == OP_ID) ? 2'd0 : 2'd2;

  function automatic logic [7:0] cmd1_byte(input logic [1:0] op);
    case (op)
      OP_READ:  return 8'h00;
      OP_PROG:  return 8'h80;
      OP_ERASE: return 8'h60;
      default:  return 8'h90;
    endcase
  endfunction

  // ERASE sends row bytes only; ID sends a single 00h
  function automatic logic [7:0] addr_byte(input logic [1:0] op, input logic [23:0] a,
                                           input logic [1:0] idx);
    if (op == OP_ID) return 8'h00;
    if (op == OP_ERASE) return (idx == 2'd0) ? a[15:8] : a[23:16];
    case (idx)
      2'd0:    return a[7:0];
      2'd1:    return a[15:8];
      default: return a[23:16];
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE; r_op <= '0; r_idx <= '0; r_addr <= '0; r_len <= '0; r_bcnt <= '0;
      r_cyc <= '0; r_tmo <= '0; r_io_out <= '0; r_rd_data <= '0; r_status <= '0;
      r_ceb <= 1'b1; r_cle <= 1'b0; r_ale <= 1'b0; r_web <= 1'b1; r_reb <= 1'b1;
      r_io_oe <= 1'b0; r_rd_valid <= 1'b0; r_wr_ready <= 1'b0; r_done <= 1'b0; r_err <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      r_wr_ready <= 1'b0;
      // strobe pacing inside a bus cycle; state arms below restart r_cyc at cycle end
      if (w_wr_st && !w_wend) begin
        r_cyc <= r_cyc + 8'd1;
        if (r_cyc == WLOW) r_web <= 1'b1;
      end
      if (w_rd_st && !w_rend) begin
        r_cyc <= r_cyc + 8'd1;
        if (r_cyc == RLOW) r_reb <= 1'b1;
      end
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_op <= req_op; r_addr <= req_addr; r_len <= req_len;
          if (req_len == 10'd0 && (req_op == OP_READ || req_op == OP_PROG)) begin
            r_state <= S_DONE; r_done <= 1'b1; r_err <= 1'b1;
          end else begin
            r_state <= S_CMD1; r_ceb <= 1'b0; r_cle <= 1'b1; r_io_oe <= 1'b1;
            r_io_out <= cmd1_byte(req_op); r_web <= 1'b0; r_cyc <= '0;
          end
        end
        S_CMD1: if (w_wend) begin
          r_state <= S_ADDR; r_cle <= 1'b0; r_ale <= 1'b1; r_idx <= 2'd0;
          r_io_out <= addr_byte(r_op, r_addr, 2'd0); r_web <= 1'b0; r_cyc <= '0;
        end
        S_ADDR: if (w_wend) begin
          if (r_idx != w_alast) begin
            r_idx <= r_idx + 2'd1; r_io_out <= addr_byte(r_op, r_addr, r_idx + 2'd1);
            r_web <= 1'b0; r_cyc <= '0;
          end else begin
            r_ale <= 1'b0;
            case (r_op)
              OP_READ:  begin r_state <= S_WAITB; r_io_oe <= 1'b0; r_tmo <= '0; end
              OP_PROG:  begin r_state <= S_WDATA; r_bcnt <= r_len; end
              OP_ERASE: begin
                r_state <= S_CMD2; r_cle <= 1'b1; r_io_out <= 8'hD0; r_web <= 1'b0; r_cyc <= '0;
              end
              default:  begin
                r_state <= S_RDATA; r_io_oe <= 1'b0; r_bcnt <= 10'd2; r_reb <= 1'b0; r_cyc <= '0;
              end
            endcase
          end
        end
        // r_cyc parks at WLAST with web high while waiting for the next byte
        S_WDATA: if (w_wend) begin
          if (r_bcnt == 10'd0) begin
            r_state <= S_CMD2; r_cle <= 1'b1; r_io_out <= 8'h10; r_web <= 1'b0; r_cyc <= '0;
          end else if (wr_valid) begin
            r_io_out <= wr_data; r_web <= 1'b0; r_cyc <= '0; r_wr_ready <= 1'b1;
            r_bcnt <= r_bcnt - 10'd1;
          end
        end
        S_CMD2: if (w_wend) begin
          r_state <= S_WAITB; r_cle <= 1'b0; r_io_oe <= 1'b0; r_tmo <= '0;
        end
        S_WAITB: begin
          if (r_tmo >= TWB && rbb) begin
            if (r_op == OP_READ) begin
              r_state <= S_RDATA; r_bcnt <= r_len; r_reb <= 1'b0; r_cyc <= '0;
            end else begin
              r_state <= S_STCMD; r_cle <= 1'b1; r_io_oe <= 1'b1; r_io_out <= 8'h70;
              r_web <= 1'b0; r_cyc <= '0;
            end
          end else if (r_tmo == TMO1) begin
            r_state <= S_DONE; r_ceb <= 1'b1; r_done <= 1'b1; r_err <= 1'b1;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_RDATA: begin
          if (r_cyc == RLOW) begin
            r_rd_data <= io_in; r_rd_valid <= 1'b1; r_bcnt <= r_bcnt - 10'd1;
          end
          if (w_rend) begin
            if (r_bcnt == 10'd0) begin
              r_state <= S_DONE; r_ceb <= 1'b1; r_done <= 1'b1; r_err <= 1'b0;
            end else begin
              r_reb <= 1'b0; r_cyc <= '0;
            end
          end
        end
        S_STCMD: if (w_wend) begin
          r_state <= S_STRD; r_cle <= 1'b0; r_io_oe <= 1'b0; r_reb <= 1'b0; r_cyc <= '0;
        end
        S_STRD: begin
          if (r_cyc == RLOW) r_status <= io_in;
          if (w_rend) begin
            r_state <= S_DONE; r_ceb <= 1'b1; r_done <= 1'b1; r_err <= r_status[0];
          end
        end
        default: begin
          r_state <= S_IDLE; r_done <= 1'b0; r_err <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign wr_ready  = r_wr_ready;
  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign done      = r_done;
  assign err       = r_err;
  assign status    = r_status;
  assign ceb       = r_ceb;
  assign cle       = r_cle;
  assign ale       = r_ale;
  assign web       = r_web;
  assign reb       = r_reb;
  assign io_out    = r_io_out;
  assign io_oe     = r_io_oe;
endmodule

// File: tb/tb_nand_bus_seq.sv
// Bench for nand_bus_seq: behavioural NAND device + byte producer, expected bus/read/status
// streams built per request from the command protocol.
module tb_nand_bus_seq;
  localparam int T_WP = 2, T_WH = 1, T_RP = 2, T_REH = 1, T_WB = 4, T_TMO = 1000;
  localparam logic [1:0] RD = 2'd0, PG = 2'd1, ER = 2'd2, ID = 2'd3;
  localparam logic [26:0] RST_EXP = {6'b111000, 8'h00, 4'b0000, 8'h00, 1'b1};

  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_ready;
  logic [1:0] req_op = '0;
  logic [23:0] req_addr = '0;
  logic [9:0] req_len = '0;
  logic [7:0] wr_data = '0;
  logic wr_valid = 1'b0, wr_ready;
  logic [7:0] rd_data, status, io_out, io_in;
  logic rd_valid, done, err, ceb, cle, ale, web, reb, io_oe;
  logic rbb = 1'b1;

  nand_bus_seq #(.T_WP(T_WP), .T_WH(T_WH), .T_RP(T_RP), .T_REH(T_REH), .T_WB(T_WB),
                 .T_TMO(T_TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_len(req_len), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
    .status(status), .ceb(ceb), .cle(cle), .ale(ale), .web(web), .reb(reb), .io_out(io_out),
    .io_oe(io_oe), .io_in(io_in), .rbb(rbb));

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [26:0] rvec();
    return {ceb, web, reb, cle, ale, io_oe, io_out, rd_valid, wr_ready, done, err, status, req_ready};
  endfunction

  // device model / producer state
  logic [7:0] rd_src [0:1023];
  logic [7:0] wr_src [0:1023];
  int rd_ptr = 0, wr_ptr = 0, wr_n = 0, wr_acks = 0, busy_len = 0, busy_left = 0;
  int t_trig = -1, t_reb_fall = -1, t_rbb_rise = -1, addr_n = 0;
  int stall_left = 0, stall_age = 0, stall_bad = 0;
  bit reb_fall_seen = 0, stall_en = 0, stall_done = 0, rand_gap = 0;
  logic [7:0] last_cmd = 8'hFF, model_status = 8'h00;
  logic p_web = 1'b1, p_reb = 1'b1;
  logic [9:0] bus_q[$];
  logic [7:0] rdv_q[$];

  assign io_in = rd_src[rd_ptr[9:0]];

  // NAND device latches {cle,ale,io} on web rise, goes busy after 3rd READ address or 10h/D0h
  initial forever begin
    @(negedge clk);
    if (!rbb && busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin rbb = 1'b1; t_rbb_rise = cyc; end
    end
    if (!rst) begin
      if (web && !p_web) begin
        bus_q.push_back({cle, ale, io_out});
        if (cle) begin last_cmd = io_out; addr_n = 0; end
        if (ale) addr_n++;
        if ((cle && (io_out == 8'h10 || io_out == 8'hD0)) || (ale && last_cmd == 8'h00 && addr_n == 3)) begin
          t_trig = cyc;
          if (busy_len > 0) begin rbb = 1'b0; busy_left = busy_len; end
        end
      end
      if (!reb && p_reb && !reb_fall_seen) begin reb_fall_seen = 1; t_reb_fall = cyc; end
      if (reb && !p_reb) rd_ptr++;
      if (rd_valid) rdv_q.push_back(rd_data);
      if (wr_ready) begin wr_acks++; wr_ptr++; end
    end
    if (stall_en && !stall_done && wr_n > 0 && wr_ptr == wr_n/2) begin
      stall_left = 100; stall_done = 1; stall_age = 0;
    end
    if (stall_left > 0) begin
      stall_left--; stall_age++;
      if (stall_age > T_WP + T_WH && !(web && !ceb)) stall_bad++;
    end
    wr_valid = (wr_ptr < wr_n) && (stall_left == 0) && (!rand_gap || $urandom_range(3) != 0);
    wr_data = wr_src[wr_ptr[9:0]];
    p_web = web; p_reb = reb;
  end

  // mode: [0] data = 20h+i, [1] 100-cycle wr_valid stall mid-page, [2] random wr_valid gaps
  task automatic run_txn(input logic [1:0] op, input logic [23:0] addr, input int len,
                         input int blen, input logic [7:0] st, input int mode, input int rst_at);
    logic [9:0] exp_q[$];
    logic [7:0] exp_rd[$];
    logic [7:0] cmd;
    logic got_err, exp_err;
    bit got_done, len0, tmo;
    int t_done;
    len0 = (op == RD || op == PG) && len == 0;
    tmo = (op != ID) && !len0 && blen > T_TMO;
    busy_len = blen; busy_left = 0; rbb = 1'b1; rd_ptr = 0; wr_ptr = 0; wr_acks = 0;
    bus_q.delete(); rdv_q.delete(); reb_fall_seen = 0; t_trig = -1; t_rbb_rise = -1;
    stall_en = mode[1]; stall_done = 0; stall_left = 0; stall_bad = 0; rand_gap = mode[2];
    wr_n = (op == PG) ? len : 0;
    for (int i = 0; i < len && i < 1024; i++) wr_src[i] = mode[0] ? 8'(32 + i) : 8'($urandom);
    if (op == RD) for (int i = 0; i < len; i++) rd_src[i] = 8'($urandom);
    else if (op == ID) begin rd_src[0] = 8'hEC; rd_src[1] = 8'hE6; end
    else rd_src[0] = st;
    // expected bus stream and read data from the command protocol
    cmd = (op == RD) ? 8'h00 : (op == PG) ? 8'h80 : (op == ER) ? 8'h60 : 8'h90;
    if (!len0) begin
      exp_q.push_back({2'b10, cmd});
      if (op == RD || op == PG) begin
        exp_q.push_back({2'b01, addr[7:0]}); exp_q.push_back({2'b01, addr[15:8]});
        exp_q.push_back({2'b01, addr[23:16]});
      end else if (op == ER) begin
        exp_q.push_back({2'b01, addr[15:8]}); exp_q.push_back({2'b01, addr[23:16]});
      end else exp_q.push_back({2'b01, 8'h00});
      if (op == PG) begin
        for (int i = 0; i < len; i++) exp_q.push_back({2'b00, wr_src[i]});
        exp_q.push_back({2'b10, 8'h10});
      end
      if (op == ER) exp_q.push_back({2'b10, 8'hD0});
      if ((op == PG || op == ER) && !tmo) exp_q.push_back({2'b10, 8'h70});
    end
    if (op == RD && !tmo) for (int i = 0; i < len; i++) exp_rd.push_back(rd_src[i]);
    if (op == ID) begin exp_rd.push_back(8'hEC); exp_rd.push_back(8'hE6); end
    exp_err = len0 || tmo || ((op == PG || op == ER) && st[0]);
    if ((op == PG || op == ER) && !len0 && !tmo) model_status = st;

    @(negedge clk);
    req_op = op; req_addr = addr; req_len = 10'(len); req_valid = 1'b1;
    got_done = 0; got_err = 1'b0; t_done = -1;
    for (int k = 0; k < 20000 && !got_done; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (rst_at > 0 && rdv_q.size() >= rst_at) begin
        #2 rst = 1'b1;
        #1 chk("rst_async", 32'(rvec()), 32'(RST_EXP));
        @(negedge clk);
        chk("rst_held", 32'(rvec()), 32'(RST_EXP));
        rst = 1'b0; model_status = 8'h00;
        @(negedge clk);
        chk("rdy_post_rst", 32'(rvec()), 32'(RST_EXP));
        return;
      end
      if (done) begin got_done = 1; got_err = err; t_done = cyc; end
    end
    chk("done_seen", 32'(got_done), 32'd1);
    chk("err", 32'(got_err), 32'(exp_err));
    chk("bus_len", bus_q.size(), exp_q.size());
    for (int i = 0; i < bus_q.size() && i < exp_q.size(); i++) begin
      chk("bus_byte", 32'(bus_q[i]), 32'(exp_q[i]));
      if (bus_q[i] !== exp_q[i]) break;
    end
    chk("rd_cnt", rdv_q.size(), exp_rd.size());
    for (int i = 0; i < rdv_q.size() && i < exp_rd.size(); i++) begin
      chk("rd_byte", 32'(rdv_q[i]), 32'(exp_rd[i]));
      if (rdv_q[i] !== exp_rd[i]) break;
    end
    chk("status", 32'(status), 32'(model_status));
    if (op == PG && !len0) chk("wr_acks", wr_acks, len);
    if (op != ID && !len0) begin
      if (tmo) chk("tmo_lat", t_done - t_trig, T_WH + T_TMO);
      else begin
        chk("twb_gap", 32'(t_reb_fall - t_trig >= T_WH + T_WB), 32'd1);
        if (blen > 0) chk("busy_wait", 32'(t_reb_fall > t_rbb_rise), 32'd1);
      end
    end
    if (mode[1]) begin
      chk("stall_hit", 32'(stall_done), 32'd1);
      chk("stall_web", stall_bad, 0);
    end
    @(negedge clk);
    chk("done_1cyc", {29'd0, done, req_ready, ceb}, 32'b011);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_vals", 32'(rvec()), 32'(RST_EXP));
    rst = 1'b0;
    @(negedge clk);
    chk("rdy_after_rst", 32'(req_ready), 32'd1);
    run_txn(RD, 24'h00E000, 16, 50, 8'h00, 0, 0);
    run_txn(PG, 24'h00E100, 528, 20, 8'hC0, 1, 0);
    run_txn(ER, 24'hE00000, 0, 30, 8'hC1, 0, 0);
    run_txn(ID, 24'($urandom), 0, 0, 8'h00, 0, 0);
    run_txn(PG, 24'h123456, 64, 10, 8'h40, 3, 0);
    run_txn(RD, 24'h00AB00, 4, 100000, 8'h00, 0, 0);
    run_txn(RD, 24'h000001, 0, 0, 8'h00, 0, 0);
    run_txn(PG, 24'h000002, 0, 0, 8'h00, 0, 0);
    run_txn(RD, 24'h00C000, 16, 5, 8'h00, 0, 5);
    run_txn(RD, 24'h00C100, 8, 12, 8'h00, 0, 0);
    for (int n = 0; n < 14; n++) begin
      logic [1:0] op;
      op = 2'($urandom_range(3));
      run_txn(op, 24'($urandom), $urandom_range(0, 40), $urandom_range(0, 60),
              8'($urandom), ($urandom_range(1) != 0) ? 4 : 0, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/nand_bus_seq.md
NAND_BUS_SEQ -- requirements
Module: nand_bus_seq

Interface
REQ-001 Parameters, one per line (name, default, meaning), all counts in clk cycles:
  T_WP, 2, web low width; T_WH, 1, web high width.
  T_RP, 2, reb low width; T_REH, 1, reb high width.
  T_WB, 4, wait after last command before rbb is sampled.
  T_TMO, 2**20-1, rbb-high timeout.
REQ-002 Ports, one per line (name, direction, width, meaning):
  clk in 1 clock; rst in 1 reset.
  req_valid in 1; req_ready out 1; req_op in 2 (0 READ, 1 PROG, 2 ERASE, 3 ID).
  req_addr in 24 (A[7:0] column, A[23:8] row); req_len in 10 (data bytes).
  wr_data in 8; wr_valid in 1; wr_ready out 1.
  rd_data out 8; rd_valid out 1; done out 1; err out 1; status out 8.
  ceb, cle, ale, web, reb out 1 each (NAND strobes).
  io_out out 8; io_oe out 1; io_in in 8; rbb in 1 (ready/busy, 1 = ready).
REQ-003 One clock; reset is asynchronous and active-high.

Function
REQ-004 FSM states: IDLE, CMD1, ADDR, WDATA, CMD2, WAITB, RDATA, STCMD, STRD, DONE.
REQ-005 req_ready = 1 only in IDLE; a request is accepted when req_valid && req_ready.
REQ-006 Bus write cycle: io_oe=1, io_out=byte, web low T_WP cycles, then high T_WH cycles; io_out is held through the web high period.
REQ-007 Bus read cycle: reb low T_RP cycles; io_in is captured on the last low cycle; reb high T_REH cycles; rd_valid pulses 1 cycle with the captured byte.
REQ-008 CMD states: cle=1, ale=0. ADDR state: ale=1, cle=0. Data states: cle=ale=0. ceb=0 from CMD1 through the end of the final read/write; ceb=1 in IDLE and DONE.
REQ-009 READ sequence: 00h; addr A[7:0], A[15:8], A[23:16]; WAITB; RDATA for req_len bytes.
REQ-010 PROG sequence: 80h; 3 addr; WDATA for req_len bytes; 10h; WAITB; STCMD 70h; STRD for 1 byte.
REQ-011 ERASE sequence: 60h; addr A[15:8], A[23:16]; D0h; WAITB; 70h; 1 status byte.
REQ-012 ID sequence: 90h; addr 00h; no WAITB; RDATA for 2 bytes.
REQ-013 WDATA: wr_ready=1 for one cycle when a byte is latched into io_out at web fall; wr_valid=0 stalls with web=1, ceb=0, and no timeout.
REQ-014 WAITB: wait T_WB cycles, then wait for rbb=1. If T_TMO cycles pass without rbb=1, go to DONE with err=1.
REQ-015 status holds the byte read in STRD and retains its value until the next status read. For PROG/ERASE, err=1 when status[0]=1.
REQ-016 DONE lasts one cycle with done=1, then returns to IDLE. err is valid with done.
REQ-017 req_len=0 for READ/PROG: no bus activity; DONE with err=1 the cycle after acceptance.
REQ-018 The byte counter is 10 bits; the maximum is 1023 bytes with no wrap. req_len>528 is passed to the device unchecked.
REQ-019 rbb falling during RDATA/WDATA is ignored.

Reset
REQ-020 rst asserted, at any time including mid-operation, forces the following within the same cycle:
  state IDLE, ceb=1, web=1, reb=1, cle=0, ale=0, io_oe=0, io_out=00h.
  rd_valid=0, wr_ready=0, done=0, err=0, status=00h.
  req_ready=1 after rst deasserts.

Verification
REQ-021 READ, addr 00E000h, len 16, rbb low 50 cycles -> bus carries 00h, 00h, E0h, 00h; rbb is not sampled before T_WB; 16 rd_valid pulses carry io_in values; done=1, err=0.
REQ-022 PROG, addr 00E100h, len 528, data 20h+i, status io_in=C0h -> 528 web pulses, then 10h, then 70h; status=C0h; err=0.
REQ-023 ERASE, row E000h, status io_in=C1h -> bus carries 60h, 00h, E0h, D0h, 70h; status=C1h; err=1.
REQ-024 ID -> bus carries 90h, 00h; io_in EC, E6 yields rd_data EC then E6; done=1.
REQ-025 PROG with wr_valid dropped for 100 cycles mid-page -> web stays high and ceb stays low through the stall; no byte is lost or duplicated; the sequence completes.
REQ-026 rbb held 0 with T_TMO=1000 -> done and err=1 1000 cycles after WAITB entry. Separately, rst during RDATA -> all REQ-020 values hold and a subsequent READ completes correctly.
